ts_overflow_monitor_mc: RTL

- Parametrised successor of the host-receive TS overflow monitor, placed in packet_map_dispatch between the packet-map stage and the CSM / TS buffer stage.
- Classifies each incoming packet from its control word and handles it one of three ways:
  - NMAC packets go to the NMAC output.
  - TS packets whose flow is flagged overflowed are discarded.
  - All other packets pass to the data output.
- Adds a monitor enable, per-flow saturating discard counters with a registered read port, global forward/discard/NMAC counters, and an error pulse tagged with the flow id.

---
 rtl/ts_overflow_monitor_mc.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ts_overflow_monitor_mc.sv
// TS overflow monitor: routes NMAC packets, drops TS packets of overflowed flows,
// forwards the rest, and keeps saturating per-flow and global packet statistics.
module ts_overflow_monitor_mc #(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned CTRL_W     = 19,
  parameter int unsigned FLOW_NUM   = 32,
  parameter int unsigned FLOW_IDX_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_W-1:0]     iv_data,
  input  logic                  i_data_wr,
  input  logic [CTRL_W-1:0]     iv_ctrl_data,
  input  logic [FLOW_NUM-1:0]   iv_ts_ovf,
  input  logic                  i_monitor_en,
  output logic [DATA_W-1:0]     ov_data,
  output logic                  o_data_wr,
  output logic [CTRL_W-1:0]     ov_ctrl_data,
  output logic [DATA_W-1:0]     ov_nmac_data,
  output logic                  o_nmac_data_wr,
  output logic                  o_pkt_cnt_pulse,
  output logic                  o_ts_ovf_err_pulse,
  output logic [FLOW_IDX_W-1:0] ov_ts_ovf_err_flow,
  input  logic                  i_cnt_rd,
  input  logic [FLOW_IDX_W-1:0] iv_cnt_addr,
  output logic [CNT_W-1:0]      ov_cnt_rdata,
  output logic                  o_cnt_rdata_valid,
  input  logic                  i_cnt_clr,
  output logic [CNT_W-1:0]      ov_fwd_cnt,
  output logic [CNT_W-1:0]      ov_disc_cnt,
  output logic [CNT_W-1:0]      ov_nmac_cnt,
  output logic [1:0]            ov_state
);

  typedef enum logic [1:0] {
    IDLE_S       = 2'd0,
    TRANS_DATA_S = 2'd1,
    TRANS_NMAC_S = 2'd2,
    DISC_DATA_S  = 2'd3
  } state_t;

  state_t                state;
  logic                  resync;
  logic [CNT_W-1:0]      flow_cnt [FLOW_NUM];

  logic                  delim;
  logic [2:0]            pkt_type;
  logic [FLOW_IDX_W-1:0] pkt_flow;
  logic                  is_head;
  logic                  is_tail;
  logic                  is_nmac;
  logic                  ovf_hit;
  logic                  do_fwd;
  logic                  do_disc;
  logic                  do_nmac;

  // Head-word classification
  assign delim    = iv_data[DATA_W-1];
  assign pkt_type = iv_ctrl_data[CTRL_W-1 -: 3];
  assign pkt_flow = iv_ctrl_data[CTRL_W-4 -: FLOW_IDX_W];
  assign is_head  = (state == IDLE_S) && i_data_wr && delim && !resync;
  assign is_tail  = (state != IDLE_S) && i_data_wr && delim;
  assign is_nmac  = (pkt_type == 3'b101);
  assign ovf_hit  = i_monitor_en && (pkt_type <= 3'd2) && iv_ts_ovf[pkt_flow];
  assign do_nmac  = is_head && is_nmac;
  assign do_disc  = is_head && !is_nmac && ovf_hit;
  assign do_fwd   = is_head && !is_nmac && !ovf_hit;

  assign ov_state = state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Packet FSM; resync swallows the remainder of a packet cut by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= IDLE_S;
      resync             <= 1'b0;
      ov_data            <= '0;
      o_data_wr          <= 1'b0;
      ov_ctrl_data       <= '0;
      ov_nmac_data       <= '0;
      o_nmac_data_wr     <= 1'b0;
      o_pkt_cnt_pulse    <= 1'b0;
      o_ts_ovf_err_pulse <= 1'b0;
      ov_ts_ovf_err_flow <= '0;
    end else begin
      o_pkt_cnt_pulse    <= is_head;
      o_ts_ovf_err_pulse <= do_disc;
      case (state)
        IDLE_S: begin
          o_data_wr      <= 1'b0;
          o_nmac_data_wr <= 1'b0;
          ov_data        <= '0;
          ov_nmac_data   <= '0;
          ov_ctrl_data   <= '0;
          if (resync) begin
            if (i_data_wr && delim) resync <= 1'b0;
          end else if (i_data_wr && !delim) begin
            resync <= 1'b1;
          end else if (do_nmac) begin
            ov_nmac_data   <= iv_data;
            o_nmac_data_wr <= 1'b1;
            state          <= TRANS_NMAC_S;
          end else if (do_disc) begin
            ov_ts_ovf_err_flow <= pkt_flow;
            state              <= DISC_DATA_S;
          end else if (do_fwd) begin
            ov_data      <= iv_data;
            o_data_wr    <= 1'b1;
            ov_ctrl_data <= iv_ctrl_data;
            state        <= TRANS_DATA_S;
          end
        end
        TRANS_DATA_S: begin
          ov_data        <= iv_data;
          o_data_wr      <= i_data_wr;
          o_nmac_data_wr <= 1'b0;
          if (is_tail) state <= IDLE_S;
        end
        TRANS_NMAC_S: begin
          ov_nmac_data   <= iv_data;
          o_nmac_data_wr <= i_data_wr;
          o_data_wr      <= 1'b0;
          if (is_tail) state <= IDLE_S;
        end
        DISC_DATA_S: begin
          o_data_wr      <= 1'b0;
          o_nmac_data_wr <= 1'b0;
          if (is_tail) state <= IDLE_S;
        end
        default: state <= IDLE_S;
      endcase
    end
  end

  // Statistics; clear wins over a same-cycle increment, reads see pre-update values
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_fwd_cnt        <= '0;
      ov_disc_cnt       <= '0;
      ov_nmac_cnt       <= '0;
      ov_cnt_rdata      <= '0;
      o_cnt_rdata_valid <= 1'b0;
      for (int unsigned i = 0; i < FLOW_NUM; i++) flow_cnt[i] <= '0;
    end else begin
      o_cnt_rdata_valid <= i_cnt_rd;
      if (i_cnt_rd) ov_cnt_rdata <= flow_cnt[iv_cnt_addr];
      if (i_cnt_clr) begin
        ov_fwd_cnt  <= '0;
        ov_disc_cnt <= '0;
        ov_nmac_cnt <= '0;
        for (int unsigned i = 0; i < FLOW_NUM; i++) flow_cnt[i] <= '0;
      end else begin
        if (do_fwd)  ov_fwd_cnt  <= sat_inc(ov_fwd_cnt);
        if (do_nmac) ov_nmac_cnt <= sat_inc(ov_nmac_cnt);
        if (do_disc) begin
          ov_disc_cnt        <= sat_inc(ov_disc_cnt);
          flow_cnt[pkt_flow] <= sat_inc(flow_cnt[pkt_flow]);
        end
      end
    end
  end

endmodule
